// File: rtl/store_commit_drainer_pkg.sv
// Shared load/store unit types: store-queue index/count paths, D-cache block
// payload widths and the store drainer state encoding.
package LoadStoreUnitTypes;

  localparam int SQ_ENTRY_NUM_DEF = 16;
  localparam int COMMIT_WIDTH_DEF = 2;
  localparam int BLOCK_ADDR_W_DEF = 29;
  localparam int BLOCK_DATA_W_DEF = 64;
  localparam int WORD_WE_W_DEF    = 2;
  localparam int BYTE_WE_W_DEF    = 4;

  localparam int SQ_INDEX_W = $clog2(SQ_ENTRY_NUM_DEF);

  typedef logic [SQ_INDEX_W-1:0]       StoreQueueIndexPath;
  typedef logic [SQ_INDEX_W:0]         StoreQueueCountPath;
  typedef logic [BLOCK_ADDR_W_DEF-1:0] BlockAddrPath;
  typedef logic [BLOCK_DATA_W_DEF-1:0] BlockDataPath;
  typedef logic [WORD_WE_W_DEF-1:0]    BlockWordWePath;
  typedef logic [BYTE_WE_W_DEF-1:0]    BlockByteWePath;

  typedef enum logic [1:0] {
    DRAIN_IDLE       = 2'd0,
    DRAIN_ISSUE      = 2'd1,
    DRAIN_WAIT_RETRY = 2'd2
  } DrainerState;

endpackage

// File: rtl/store_drain_payload_reg.sv
// Holding register for the store being written to the D-cache. Loaded once
// when the drainer leaves IDLE so the request payload stays frozen while the
// cache applies backpressure.
module store_drain_payload_reg #(
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 64,
  parameter int WORD_WE_W = 2,
  parameter int BYTE_WE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_data,
  input  logic [WORD_WE_W-1:0] i_word_we,
  input  logic [BYTE_WE_W-1:0] i_byte_we,
  output logic [ADDR_W-1:0]    o_addr,
  output logic [DATA_W-1:0]    o_data,
  output logic [WORD_WE_W-1:0] o_word_we,
  output logic [BYTE_WE_W-1:0] o_byte_we
);

  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_data;
  logic [WORD_WE_W-1:0] r_word_we;
  logic [BYTE_WE_W-1:0] r_byte_we;

  // Capture the SQ entry on load; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_word_we <= '0;
      r_byte_we <= '0;
    end else if (i_load) begin
      r_addr    <= i_addr;
      r_data    <= i_data;
      r_word_we <= i_word_we;
      r_byte_we <= i_byte_we;
    end
  end

  assign o_addr    = r_addr;
  assign o_data    = r_data;
  assign o_word_we = r_word_we;
  assign o_byte_we = r_byte_we;

endmodule

// File: rtl/store_commit_drainer.sv
// Drains committed stores from the store queue head into the D-cache, one
// entry at a time, in commit order. Suppressed stores are released without a
// cache write. Committed stores are architectural, so nothing but reset
// stops the drain.
//
//   state            | meaning
//   -----------------+--------------------------------------------------
//   DRAIN_IDLE       | look at SQ head; release suppressed store or latch
//   DRAIN_ISSUE      | first cycle of cache write request
//   DRAIN_WAIT_RETRY | cache refused; hold request and payload until ack
module store_commit_drainer
  import LoadStoreUnitTypes::*;
#(
  parameter int SQ_ENTRY_NUM = SQ_ENTRY_NUM_DEF,
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
  parameter int BLOCK_ADDR_W = BLOCK_ADDR_W_DEF,
  parameter int BLOCK_DATA_W = BLOCK_DATA_W_DEF,
  parameter int WORD_WE_W    = WORD_WE_W_DEF,
  parameter int BYTE_WE_W    = BYTE_WE_W_DEF,
  localparam int IDX_W = $clog2(SQ_ENTRY_NUM),
  localparam int CNT_W = IDX_W + 1,
  localparam int NUM_W = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_W-1:0]        commitStoreNum,
  output logic [IDX_W-1:0]        retiredStoreQueuePtr,
  input  logic [BLOCK_ADDR_W-1:0] retiredStoreAddr,
  input  logic [BLOCK_DATA_W-1:0] retiredStoreData,
  input  logic [WORD_WE_W-1:0]    retiredStoreWordWE,
  input  logic [BYTE_WE_W-1:0]    retiredStoreByteWE,
  input  logic                    retiredStoreCondEnabled,
  output logic                    dcWriteReq,
  output logic [BLOCK_ADDR_W-1:0] dcWriteAddr,
  output logic [BLOCK_DATA_W-1:0] dcWriteData,
  output logic [WORD_WE_W-1:0]    dcWriteWordWE,
  output logic [BYTE_WE_W-1:0]    dcWriteByteWE,
  input  logic                    dcWriteAck,
  output logic                    releaseStoreQueueHead,
  output logic [NUM_W-1:0]        releaseStoreQueueHeadEntryNum,
  output logic [CNT_W-1:0]        pendingCount,
  output logic                    drainerIdle
);

  DrainerState      r_state;
  DrainerState      w_state_next;
  logic [IDX_W-1:0] r_drain_ptr;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W:0]   w_pending_sum;
  logic             w_release;
  logic             w_latch;
  logic             w_req;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= DRAIN_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, release and request decode.
  always_comb begin
    w_state_next = r_state;
    w_release    = 1'b0;
    w_latch      = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      DRAIN_IDLE: begin
        if (r_pending != '0) begin
          if (!retiredStoreCondEnabled) begin
            w_release = 1'b1;
          end else begin
            w_latch      = 1'b1;
            w_state_next = DRAIN_ISSUE;
          end
        end
      end
      DRAIN_ISSUE, DRAIN_WAIT_RETRY: begin
        w_req = 1'b1;
        if (dcWriteAck) begin
          w_release    = 1'b1;
          w_state_next = DRAIN_IDLE;
        end else begin
          w_state_next = DRAIN_WAIT_RETRY;
        end
      end
      default: w_state_next = DRAIN_IDLE;
    endcase
  end

  // One extra bit so overflow and underflow stay visible to the checks below.
  assign w_pending_sum = {1'b0, r_pending} + (CNT_W+1)'(commitStoreNum)
                       - (CNT_W+1)'(w_release);

  // Pending count and drain pointer; the pointer wraps naturally (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_drain_ptr <= '0;
    end else begin
      r_pending <= w_pending_sum[CNT_W-1:0];
      if (w_release) r_drain_ptr <= r_drain_ptr + IDX_W'(1);
    end
  end

  store_drain_payload_reg #(
    .ADDR_W   (BLOCK_ADDR_W),
    .DATA_W   (BLOCK_DATA_W),
    .WORD_WE_W(WORD_WE_W),
    .BYTE_WE_W(BYTE_WE_W)
  ) u_payload (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_latch),
    .i_addr   (retiredStoreAddr),
    .i_data   (retiredStoreData),
    .i_word_we(retiredStoreWordWE),
    .i_byte_we(retiredStoreByteWE),
    .o_addr   (dcWriteAddr),
    .o_data   (dcWriteData),
    .o_word_we(dcWriteWordWE),
    .o_byte_we(dcWriteByteWE)
  );

  assign retiredStoreQueuePtr          = r_drain_ptr;
  assign dcWriteReq                    = w_req;
  assign releaseStoreQueueHead         = w_release;
  assign releaseStoreQueueHeadEntryNum = NUM_W'(w_release);
  assign pendingCount                  = r_pending;
  assign drainerIdle                   = (r_pending == '0) && (r_state == DRAIN_IDLE);

  // Protocol sanity: no SQ overflow, no release from empty, no stray ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (w_pending_sum <= (CNT_W+1)'(SQ_ENTRY_NUM));
      assert (!(w_release && (r_pending == '0)));
      assert (!(dcWriteAck && !w_req));
    end
  end

endmodule

// File: tb/tb_store_commit_drainer.sv
module tb_store_commit_drainer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  commitStoreNum;
  logic [3:0]  retiredStoreQueuePtr;
  logic [28:0] retiredStoreAddr;
  logic [63:0] retiredStoreData;
  logic [1:0]  retiredStoreWordWE;
  logic [3:0]  retiredStoreByteWE;
  logic        retiredStoreCondEnabled;
  logic        dcWriteReq;
  logic [28:0] dcWriteAddr;
  logic [63:0] dcWriteData;
  logic [1:0]  dcWriteWordWE;
  logic [3:0]  dcWriteByteWE;
  logic        dcWriteAck;
  logic        releaseStoreQueueHead;
  logic [1:0]  releaseStoreQueueHeadEntryNum;
  logic [4:0]  pendingCount;
  logic        drainerIdle;

  always #5 clk = ~clk;

  store_commit_drainer dut (
    .clk                          (clk),
    .rst                          (rst),
    .commitStoreNum               (commitStoreNum),
    .retiredStoreQueuePtr         (retiredStoreQueuePtr),
    .retiredStoreAddr             (retiredStoreAddr),
    .retiredStoreData             (retiredStoreData),
    .retiredStoreWordWE           (retiredStoreWordWE),
    .retiredStoreByteWE           (retiredStoreByteWE),
    .retiredStoreCondEnabled      (retiredStoreCondEnabled),
    .dcWriteReq                   (dcWriteReq),
    .dcWriteAddr                  (dcWriteAddr),
    .dcWriteData                  (dcWriteData),
    .dcWriteWordWE                (dcWriteWordWE),
    .dcWriteByteWE                (dcWriteByteWE),
    .dcWriteAck                   (dcWriteAck),
    .releaseStoreQueueHead        (releaseStoreQueueHead),
    .releaseStoreQueueHeadEntryNum(releaseStoreQueueHeadEntryNum),
    .pendingCount                 (pendingCount),
    .drainerIdle                  (drainerIdle)
  );

  // Store queue contents as the bench wrote them at commit time.
  logic [28:0] sq_addr [16];
  logic [63:0] sq_data [16];
  logic [1:0]  sq_wwe  [16];
  logic [3:0]  sq_bwe  [16];
  logic        sq_cond [16];

  assign retiredStoreAddr        = sq_addr[retiredStoreQueuePtr];
  assign retiredStoreData        = sq_data[retiredStoreQueuePtr];
  assign retiredStoreWordWE      = sq_wwe[retiredStoreQueuePtr];
  assign retiredStoreByteWE      = sq_bwe[retiredStoreQueuePtr];
  assign retiredStoreCondEnabled = sq_cond[retiredStoreQueuePtr];

  typedef struct {
    int          idx;
    logic [28:0] addr;
    logic [63:0] data;
    logic [1:0]  wwe;
    logic [3:0]  bwe;
    logic        cond;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tb_tail  = 0;

  task automatic put_entry(input logic [28:0] a, input logic [63:0] d, input logic [1:0] w,
                           input logic [3:0] b, input logic c, output ent_t e);
    sq_addr[tb_tail] = a;
    sq_data[tb_tail] = d;
    sq_wwe[tb_tail]  = w;
    sq_bwe[tb_tail]  = b;
    sq_cond[tb_tail] = c;
    e.idx  = tb_tail;
    e.addr = a;
    e.data = d;
    e.wwe  = w;
    e.bwe  = b;
    e.cond = c;
    tb_tail = (tb_tail + 1) % 16;
  endtask

  task automatic put_random(input logic c, output ent_t e);
    put_entry(29'($urandom), {$urandom, $urandom}, 2'($urandom), 4'($urandom), c, e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [98:0] payload_of(input ent_t e);
    return {e.addr, e.data, e.wwe, e.bwe};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    commitStoreNum = '0;
    dcWriteAck = 1'b0;
    repeat (3) step;
    n_checks++; if (dcWriteReq !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", dcWriteReq); end
    n_checks++; if (releaseStoreQueueHead !== 1'b0) begin n_fail++; $display("FAIL reset_release got %0b want 0", releaseStoreQueueHead); end
    n_checks++; if (releaseStoreQueueHeadEntryNum !== 2'd0) begin n_fail++; $display("FAIL reset_entrynum got %0d want 0", releaseStoreQueueHeadEntryNum); end
    n_checks++; if (pendingCount !== 5'd0) begin n_fail++; $display("FAIL reset_pending got %0d want 0", pendingCount); end
    n_checks++; if (retiredStoreQueuePtr !== 4'd0) begin n_fail++; $display("FAIL reset_ptr got %0d want 0", retiredStoreQueuePtr); end
    n_checks++; if (drainerIdle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %0b want 1", drainerIdle); end
    n_checks++; if ({dcWriteAddr, dcWriteData} !== '0) begin n_fail++; $display("FAIL reset_payload got %0h/%0h want 0", dcWriteAddr, dcWriteData); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_single_store;
    ent_t e;
    put_entry(29'h100, {$urandom, $urandom}, 2'b11, 4'hF, 1'b1, e);
    commitStoreNum = 2'd1; #1;
    n_checks++; if (pendingCount !== 5'd0) begin n_fail++; $display("FAIL single_pend_t0 got %0d want 0", pendingCount); end
    step;
    commitStoreNum = 2'd0; #1;
    n_checks++; if (pendingCount !== 5'd1) begin n_fail++; $display("FAIL single_pend_t1 got %0d want 1", pendingCount); end
    n_checks++; if (dcWriteReq !== 1'b0) begin n_fail++; $display("FAIL single_req_t1 got %0b want 0", dcWriteReq); end
    step;
    dcWriteAck = 1'b1; #1;
    n_checks++; if (dcWriteReq !== 1'b1) begin n_fail++; $display("FAIL single_req_t2 got %0b want 1", dcWriteReq); end
    n_checks++; if ({dcWriteAddr, dcWriteData, dcWriteWordWE, dcWriteByteWE} !== payload_of(e)) begin
      n_fail++; $display("FAIL single_payload got %0h/%0h want %0h/%0h", dcWriteAddr, dcWriteData, e.addr, e.data); end
    n_checks++; if (releaseStoreQueueHead !== 1'b1 || releaseStoreQueueHeadEntryNum !== 2'd1) begin
      n_fail++; $display("FAIL single_release_t2 got %0b/%0d want 1/1", releaseStoreQueueHead, releaseStoreQueueHeadEntryNum); end
    step;
    dcWriteAck = 1'b0; #1;
    n_checks++; if (drainerIdle !== 1'b1 || pendingCount !== 5'd0) begin
      n_fail++; $display("FAIL single_idle_t3 got idle=%0b pend=%0d want 1/0", drainerIdle, pendingCount); end
    n_checks++; if (retiredStoreQueuePtr !== 4'(e.idx + 1)) begin
      n_fail++; $display("FAIL single_ptr got %0d want %0d", retiredStoreQueuePtr, (e.idx + 1) % 16); end
    step;
  endtask

  task automatic test_backpressure;
    ent_t e;
    put_random(1'b1, e);
    commitStoreNum = 2'd1; step;
    commitStoreNum = 2'd0; step;
    for (int i = 0; i < 5; i++) begin
      dcWriteAck = 1'b0; #1;
      n_checks++; if (dcWriteReq !== 1'b1 || releaseStoreQueueHead !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_%0d got req=%0b rel=%0b want 1/0", i, dcWriteReq, releaseStoreQueueHead); end
      n_checks++; if ({dcWriteAddr, dcWriteData, dcWriteWordWE, dcWriteByteWE} !== payload_of(e)) begin
        n_fail++; $display("FAIL bp_payload_%0d got %0h/%0h want %0h/%0h", i, dcWriteAddr, dcWriteData, e.addr, e.data); end
      step;
    end
    dcWriteAck = 1'b1; #1;
    n_checks++; if (dcWriteReq !== 1'b1 || releaseStoreQueueHead !== 1'b1) begin
      n_fail++; $display("FAIL bp_ack got req=%0b rel=%0b want 1/1", dcWriteReq, releaseStoreQueueHead); end
    n_checks++; if ({dcWriteAddr, dcWriteData, dcWriteWordWE, dcWriteByteWE} !== payload_of(e)) begin
      n_fail++; $display("FAIL bp_payload_ack got %0h want %0h", dcWriteAddr, e.addr); end
    step;
    dcWriteAck = 1'b0; #1;
    n_checks++; if (drainerIdle !== 1'b1 || releaseStoreQueueHead !== 1'b0) begin
      n_fail++; $display("FAIL bp_after got idle=%0b rel=%0b want 1/0", drainerIdle, releaseStoreQueueHead); end
    step;
  endtask

  task automatic test_suppressed;
    ent_t e;
    put_random(1'b0, e);
    commitStoreNum = 2'd1; #1;
    n_checks++; if (releaseStoreQueueHead !== 1'b0) begin n_fail++; $display("FAIL supp_rel_t0 got %0b want 0", releaseStoreQueueHead); end
    step;
    commitStoreNum = 2'd0; #1;
    n_checks++; if (releaseStoreQueueHead !== 1'b1 || dcWriteReq !== 1'b0) begin
      n_fail++; $display("FAIL supp_t1 got rel=%0b req=%0b want 1/0", releaseStoreQueueHead, dcWriteReq); end
    n_checks++; if (retiredStoreQueuePtr !== 4'(e.idx)) begin
      n_fail++; $display("FAIL supp_ptr got %0d want %0d", retiredStoreQueuePtr, e.idx); end
    step;
    #1;
    n_checks++; if (dcWriteReq !== 1'b0 || pendingCount !== 5'd0 || drainerIdle !== 1'b1) begin
      n_fail++; $display("FAIL supp_t2 got req=%0b pend=%0d idle=%0b want 0/0/1", dcWriteReq, pendingCount, drainerIdle); end
    step;
  endtask

  task automatic test_simultaneous;
    ent_t e;
    int   waited;
    put_random(1'b1, e);
    put_random(1'b1, e);
    commitStoreNum = 2'd2; step;
    put_random(1'b1, e);
    commitStoreNum = 2'd1; step;
    put_random(1'b1, e);
    commitStoreNum = 2'd1; dcWriteAck = 1'b1; #1;
    n_checks++; if (pendingCount !== 5'd3 || releaseStoreQueueHead !== 1'b1) begin
      n_fail++; $display("FAIL simul_pre got pend=%0d rel=%0b want 3/1", pendingCount, releaseStoreQueueHead); end
    step;
    commitStoreNum = 2'd0; dcWriteAck = 1'b0; #1;
    n_checks++; if (pendingCount !== 5'd3) begin n_fail++; $display("FAIL simul_pend got %0d want 3", pendingCount); end
    waited = 0;
    while (!drainerIdle && waited < 40) begin
      dcWriteAck = dcWriteReq;
      step;
      waited++;
    end
    dcWriteAck = 1'b0; #1;
    n_checks++; if (drainerIdle !== 1'b1 || pendingCount !== 5'd0) begin
      n_fail++; $display("FAIL simul_drain_timeout got idle=%0b pend=%0d want 1/0", drainerIdle, pendingCount); end
    step;
  endtask

  // mode 0: burst of 2 commits/cycle with always-ready cache; mode 1: random.
  task automatic test_stream(input int mode, input int stim_cycles);
    ent_t        e;
    ent_t        f;
    ent_t        fresh[$];
    logic [98:0] held;
    logic        have_hold;
    int          committed, released, n;
    logic        saw15;
    committed = 0; released = 0; have_hold = 1'b0; saw15 = 1'b0;
    q.delete();
    for (int c = 0; c < stim_cycles + 300; c++) begin
      if (c >= stim_cycles && q.size() == 0 && drainerIdle) break;
      n = 0;
      if (c < stim_cycles) begin
        if (mode == 0) n = 2;
        else begin
          n = $urandom_range(0, 2);
          if (q.size() + n > 14) n = 0;
        end
      end
      fresh.delete();
      for (int k = 0; k < n; k++) begin
        put_random((mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0), e);
        fresh.push_back(e);
      end
      commitStoreNum = 2'(n);
      dcWriteAck = dcWriteReq && ((mode == 0) || ($urandom_range(0, 1) == 1));
      #1;
      n_checks++; if (pendingCount !== 5'(q.size())) begin
        n_fail++; $display("FAIL stream%0d_pending c=%0d got %0d want %0d", mode, c, pendingCount, q.size()); end
      n_checks++; if (releaseStoreQueueHeadEntryNum !== {1'b0, releaseStoreQueueHead}) begin
        n_fail++; $display("FAIL stream%0d_entrynum got %0d want %0d", mode, releaseStoreQueueHeadEntryNum, releaseStoreQueueHead); end
      if (have_hold) begin
        n_checks++; if (dcWriteReq !== 1'b1 || {dcWriteAddr, dcWriteData, dcWriteWordWE, dcWriteByteWE} !== held) begin
          n_fail++; $display("FAIL stream%0d_hold c=%0d got req=%0b addr=%0h want req=1 stable", mode, c, dcWriteReq, dcWriteAddr); end
      end
      if (releaseStoreQueueHead === 1'b1) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream%0d_spurious_release c=%0d got release want none", mode, c);
        end else begin
          f = q.pop_front();
          if (retiredStoreQueuePtr !== 4'(f.idx)) begin
            n_fail++; $display("FAIL stream%0d_order got ptr %0d want %0d", mode, retiredStoreQueuePtr, f.idx); end
          n_checks++;
          if (f.cond) begin
            if (!(dcWriteReq && dcWriteAck) ||
                {dcWriteAddr, dcWriteData, dcWriteWordWE, dcWriteByteWE} !== payload_of(f)) begin
              n_fail++; $display("FAIL stream%0d_write idx=%0d got req=%0b addr=%0h want req=1 addr=%0h", mode, f.idx, dcWriteReq, dcWriteAddr, f.addr); end
          end else if (dcWriteReq !== 1'b0) begin
            n_fail++; $display("FAIL stream%0d_suppressed idx=%0d got req=1 want 0", mode, f.idx);
          end
          if (f.idx == 15) saw15 = 1'b1;
          released++;
        end
      end
      have_hold = dcWriteReq && !dcWriteAck;
      held = {dcWriteAddr, dcWriteData, dcWriteWordWE, dcWriteByteWE};
      foreach (fresh[k]) q.push_back(fresh[k]);
      committed += n;
      step;
    end
    commitStoreNum = '0; dcWriteAck = 1'b0; #1;
    n_checks++; if (q.size() != 0 || drainerIdle !== 1'b1) begin
      n_fail++; $display("FAIL stream%0d_drain_timeout got left=%0d idle=%0b want 0/1", mode, q.size(), drainerIdle); end
    n_checks++; if (released != committed) begin
      n_fail++; $display("FAIL stream%0d_count got %0d want %0d", mode, released, committed); end
    n_checks++; if (retiredStoreQueuePtr !== 4'(tb_tail)) begin
      n_fail++; $display("FAIL stream%0d_final_ptr got %0d want %0d", mode, retiredStoreQueuePtr, tb_tail); end
    if (mode == 0) begin
      n_checks++; if (!saw15 || committed != 16) begin
        n_fail++; $display("FAIL burst_wrap got saw15=%0b n=%0d want 1/16", saw15, committed); end
    end
    step;
  endtask

  task automatic test_reset_in_wait;
    ent_t e;
    put_random(1'b1, e);
    commitStoreNum = 2'd1; step;
    commitStoreNum = 2'd0; step;
    dcWriteAck = 1'b0; #1;
    n_checks++; if (dcWriteReq !== 1'b1) begin n_fail++; $display("FAIL rstw_issue got %0b want 1", dcWriteReq); end
    step;
    #1;
    n_checks++; if (dcWriteReq !== 1'b1) begin n_fail++; $display("FAIL rstw_wait got %0b want 1", dcWriteReq); end
    rst = 1'b1; commitStoreNum = 2'd1;
    step;
    rst = 1'b0; commitStoreNum = 2'd0; #1;
    n_checks++; if (dcWriteReq !== 1'b0 || pendingCount !== 5'd0 || retiredStoreQueuePtr !== 4'd0) begin
      n_fail++; $display("FAIL rstw_after got req=%0b pend=%0d ptr=%0d want 0/0/0", dcWriteReq, pendingCount, retiredStoreQueuePtr); end
    tb_tail = 0;
    step;
    #1;
    n_checks++; if (pendingCount !== 5'd0 || drainerIdle !== 1'b1) begin
      n_fail++; $display("FAIL rstw_commit_ignored got pend=%0d idle=%0b want 0/1", pendingCount, drainerIdle); end
    step;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sq_addr[i] = '0; sq_data[i] = '0; sq_wwe[i] = '0; sq_bwe[i] = '0; sq_cond[i] = 1'b0;
    end
    rst = 1'b1; commitStoreNum = '0; dcWriteAck = 1'b0;
    #1;
    test_reset;
    test_single_store;
    test_backpressure;
    test_suppressed;
    test_simultaneous;
    test_stream(0, 8);
    test_stream(1, 300);
    test_reset_in_wait;
    test_stream(1, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
